// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. An operation is taken
// from one requester at a time (round-robin on ties). Its opcode and operands
// are registered onto the ALU inputs, and the ALU result and flags are captured
// one cycle later. They are returned with the requester ID on a response
// channel.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready            request handshake, N = 0,1
//   reqN_op, reqN_a, reqN_b     opcode and operands of requester N
//   alu_op, alu_a, alu_b        registered opcode/operands driven to the ALU
//   alu_out, alu_*              ALU result and flags
//   rsp_valid/ready             response handshake
//   rsp_id, rsp_out, rsp_flags  requester ID, result,
//                               flags {odd_parity, negative, carry, overflow, zero}
//   busy                        high while in EXEC or RESP
//   op_count                    completed responses (wraps)
//   dbg_state                   FSM state (0 IDLE, 1 EXEC, 2 RESP)
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. A producer keeps valid and its
// payload stable until that edge. reqN_ready is high only in IDLE, only for the
// granted requester, and only while that requester's valid is high.
// rsp_valid stays high with a stable payload until rsp_ready is seen.
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry,
    input  logic             alu_negative,
    input  logic             alu_odd_parity,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_out,
    output logic [4:0]       rsp_flags,
    output logic             busy,
    output logic [15:0]      op_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   grant;
    logic   accept;

    // Only one valid: that requester wins. Both valid: the one not served last.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end
    end

    // rst_n is included so that no ready is shown while reset is held, even
    // when a requester already has valid high.
    assign accept     = (state == S_IDLE) && (req0_valid || req1_valid) && rst_n;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_out    <= '0;
            rsp_flags  <= '0;
            busy       <= 1'b0;
            op_count   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_op     <= grant ? req1_op : req0_op;
                        alu_a      <= grant ? req1_a  : req0_a;
                        alu_b      <= grant ? req1_b  : req0_b;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        busy       <= 1'b1;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // ALU inputs have been stable for a full cycle; take the result.
                    rsp_out   <= alu_out;
                    rsp_flags <= {alu_odd_parity, alu_negative, alu_carry,
                                  alu_overflow, alu_zero};
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Bench for alu_arbiter. A small ALU model drives the DUT's ALU inputs.
// Directed operations are issued through a driver task, which pushes the
// hand-computed response {id, flags, out} into exp_q on acceptance. A monitor
// pops and compares on every response handshake.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [3:0]   req0_op = '0, req1_op = '0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         alu_zero, alu_overflow, alu_carry, alu_negative, alu_odd_parity;
    logic         rsp_valid, rsp_id, busy;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_out;
    logic [4:0]   rsp_flags;
    logic [15:0]  op_count;
    logic [1:0]   dbg_state;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
        .alu_carry(alu_carry), .alu_negative(alu_negative),
        .alu_odd_parity(alu_odd_parity),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_flags(rsp_flags),
        .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
    );

    // ---------------- ALU model ----------------
    logic [32:0] wide;
    always_comb begin
        wide         = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            4'b0101: begin
                wide = {1'b0, alu_a} + {1'b0, alu_b};
                alu_overflow = (alu_a[31] == alu_b[31]) && (wide[31] != alu_a[31]);
            end
            4'b0100: begin
                wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
                alu_overflow = (alu_a[31] != alu_b[31]) && (wide[31] != alu_a[31]);
            end
            4'b0001: wide = {1'b0, alu_a ^ alu_b};
            4'b0010: wide = {1'b0, alu_a & alu_b};
            4'b0011: wide = {1'b0, alu_a | alu_b};
            default: wide = {1'b0, alu_a};
        endcase
        alu_out        = wide[31:0];
        alu_carry      = wide[32];
        alu_zero       = (wide[31:0] == 32'd0);
        alu_negative   = wide[31];
        alu_odd_parity = ^wide[31:0];
    end

    // ---------------- scoreboard ----------------
    logic [37:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [37:0] mk(input logic id, input logic [4:0] fl,
                                       input logic [31:0] o);
        return {id, fl, o};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout", name);
    endtask

    // Monitor: a handshake seen at the negedge completes on the next posedge.
    // Inputs change only just after posedges, so this sample matches the edge.
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_response");
            end else begin
                logic [37:0] e;
                e = exp_q.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e[37]));
                check("rsp_flags", 64'(rsp_flags), 64'(e[36:32]));
                check("rsp_out", 64'(rsp_out), 64'(e[31:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic r, input logic v, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        if (r) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    // Issue one operation and check the one-cycle ready pulse and the
    // two-cycle latency to rsp_valid.
    task automatic send(input logic r, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [37:0] e);
        int n;
        logic rdy;
        n = 0;
        @(posedge clk); #1;
        drive_req(r, 1'b1, op, a, b);
        @(negedge clk);
        rdy = r ? req1_ready : req0_ready;
        while (!rdy) begin
            n++;
            if (n > 50) begin
                fail_now("send_ready");
                drive_req(r, 1'b0, op, a, b);
                return;
            end
            @(negedge clk);
            rdy = r ? req1_ready : req0_ready;
        end
        exp_q.push_back(e);
        @(posedge clk); #1;
        drive_req(r, 1'b0, op, a, b);
        check("busy_in_exec", 64'(busy), 64'd1);
        check("ready_pulse", 64'(r ? req1_ready : req0_ready), 64'd0);
        check("rsp_valid_exec", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        check("rsp_valid_latency", 64'(rsp_valid), 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk); #2;
        while (exp_q.size() != 0 || rsp_valid) begin
            n++;
            if (n > 50) begin
                fail_now("drain");
                return;
            end
            @(posedge clk); #2;
        end
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        int n;
        logic [1:0] order [4];

        // Reset values, with a requester already valid while reset is held.
        rsp_ready = 1'b1;
        drive_req(1'b0, 1'b1, 4'b0101, 32'd7, 32'd7);
        repeat (3) @(negedge clk);
        check("rst_req0_ready", 64'(req0_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_rsp_out", 64'(rsp_out), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        drive_req(1'b0, 1'b0, 4'b0000, 32'd0, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 2 + 3 = 5 from req0.
        send(1'b0, 4'b0101, 32'd2, 32'd3, mk(1'b0, 5'b00000, 32'd5));
        drain();
        check("op_count_1", 64'(op_count), 64'd1);
        check("alu_hold_op", 64'(alu_op), 64'h5);

        // req1: 5 - 5 = 0 (zero, carry=no borrow), then logic ops.
        send(1'b1, 4'b0100, 32'd5, 32'd5, mk(1'b1, 5'b00101, 32'd0));
        send(1'b1, 4'b0001, 32'd2, 32'd2, mk(1'b1, 5'b00001, 32'd0));
        send(1'b1, 4'b0010, 32'd8, 32'd8, mk(1'b1, 5'b10000, 32'd8));
        send(1'b1, 4'b0011, 32'd2, 32'd3, mk(1'b1, 5'b00000, 32'd3));
        // Unknown opcode: this bench's ALU passes a through.
        send(1'b0, 4'b1111, 32'h8000_0001, 32'd9, mk(1'b0, 5'b01000, 32'h8000_0001));
        drain();
        check("op_count_6", 64'(op_count), 64'd6);

        // Response stall with req1 pending.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(1'b0, 4'b0101, 32'd2, 32'd3, mk(1'b0, 5'b00000, 32'd5));
        drive_req(1'b1, 1'b1, 4'b0011, 32'd2, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
            check("stall_rsp_out", 64'(rsp_out), 64'd5);
            check("stall_req1_ready", 64'(req1_ready), 64'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);   // monitor takes the response here
        @(negedge clk);   // first IDLE cycle after the handshake
        check("stall_first_idle_accept", 64'(req1_ready), 64'd1);
        exp_q.push_back(mk(1'b1, 5'b00000, 32'd3));
        @(posedge clk); #1;
        drive_req(1'b1, 1'b0, 4'b0011, 32'd2, 32'd3);
        drain();
        check("op_count_8", 64'(op_count), 64'd8);

        // Reset during EXEC: operation dropped.
        @(posedge clk); #1;
        drive_req(1'b0, 1'b1, 4'b0100, 32'd9, 32'd4);
        @(negedge clk);
        check("pre_rst_accept", 64'(req0_ready), 64'd1);
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 4'b0100, 32'd9, 32'd4);
        check("pre_rst_in_exec", 64'(dbg_state), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_op_count", 64'(op_count), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        check("mid_rst_alu_op", 64'(alu_op), 64'd0);
        check("mid_rst_rsp_out", 64'(rsp_out), 64'd0);

        // Both valid continuously from reset: req0, req1, req0, req1.
        drive_req(1'b0, 1'b1, 4'b0101, 32'd1, 32'd1);
        drive_req(1'b1, 1'b1, 4'b0011, 32'd4, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && n < 50) begin
                n++;
                @(negedge clk);
            end
            if (n >= 50) begin
                fail_now("tie_grant");
                break;
            end
            check("tie_grant_order", 64'({req1_ready, req0_ready}), 64'(order[k]));
            if (order[k][1]) exp_q.push_back(mk(1'b1, 5'b00000, 32'd5));
            else             exp_q.push_back(mk(1'b0, 5'b10000, 32'd2));
            @(posedge clk); #1;
            if (k == 3) begin
                drive_req(1'b0, 1'b0, 4'b0101, 32'd1, 32'd1);
                drive_req(1'b1, 1'b0, 4'b0011, 32'd4, 32'd1);
            end
        end
        drain();
        check("op_count_4", 64'(op_count), 64'd4);

        // op_count wrap.
        @(posedge clk); #1;
        force dut.op_count = 16'hFFFF;
        #1;
        release dut.op_count;
        #1;
        check("op_count_preload", 64'(op_count), 64'hFFFF);
        send(1'b1, 4'b0101, 32'hFFFF_FFFF, 32'd1, mk(1'b1, 5'b00101, 32'd0));
        drain();
        check("op_count_wrap", 64'(op_count), 64'd0);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard ceiling so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
